mul_div_unit: RTL

MUL_DIV_UNIT -- requirements
Module: mul_div_unit

---
 rtl/mul_div_unit_pkg.sv | 34 +++
 rtl/mul_div_step.sv | 30 +++
 rtl/mul_div_unit.sv | 134 +++++++++++++
 3 files changed

// File: rtl/mul_div_unit_pkg.sv
// Shared RV32M funct3 op encodings, FSM state type and operand-sign helpers
// for the iterative multiply/divide unit.
package mul_div_unit_pkg;

  localparam logic [2:0] MULDIV_MUL    = 3'd0;
  localparam logic [2:0] MULDIV_MULH   = 3'd1;
  localparam logic [2:0] MULDIV_MULHSU = 3'd2;
  localparam logic [2:0] MULDIV_MULHU  = 3'd3;
  localparam logic [2:0] MULDIV_DIV    = 3'd4;
  localparam logic [2:0] MULDIV_DIVU   = 3'd5;
  localparam logic [2:0] MULDIV_REM    = 3'd6;
  localparam logic [2:0] MULDIV_REMU   = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic is_div(input logic [2:0] op);
    return op[2];
  endfunction

  function automatic logic a_signed(input logic [2:0] op);
    return (op == MULDIV_MUL) || (op == MULDIV_MULH) || (op == MULDIV_MULHSU) ||
           (op == MULDIV_DIV) || (op == MULDIV_REM);
  endfunction

  function automatic logic b_signed(input logic [2:0] op);
    return (op == MULDIV_MUL) || (op == MULDIV_MULH) ||
           (op == MULDIV_DIV) || (op == MULDIV_REM);
  endfunction

endpackage

// File: rtl/mul_div_step.sv
// One iteration of the shared datapath: LSB-first shift-add for multiply,
// restoring trial subtract for divide. Purely combinational.
module mul_div_step #(
  parameter int WIDTH = 32
) (
  input  logic                 is_div,
  input  logic [2*WIDTH-1:0]   acc,
  input  logic [WIDTH-1:0]     opnd,
  output logic [2*WIDTH-1:0]   acc_next
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] diff;

  always_comb begin
    sum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    rem_sh = acc[2*WIDTH-1:WIDTH-1];
    diff   = rem_sh - {1'b0, opnd};
    acc_next = {sum, acc[WIDTH-1:1]};
    if (is_div) begin
      // Remainder stays below the divisor, so the difference fits in WIDTH bits.
      if (rem_sh >= {1'b0, opnd})
        acc_next = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      else
        acc_next = {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit: magnitudes run through WIDTH shift-add or
// restoring-subtract steps in one 2*WIDTH accumulator; result valid WIDTH+1 cycles after accept.
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int OP_BITS = 3
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [OP_BITS-1:0] op,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   Out
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t             state;
  logic [CW-1:0]      cnt;
  logic [2:0]         op_q;
  logic [WIDTH-1:0]   opnd;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_next;
  logic               neg_q;
  logic               div_q;

  logic [2:0]         op_in;
  logic               a_neg;
  logic               b_neg;
  logic               neg_in;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;

  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   result;

  assign in_ready = (state == IDLE);
  assign div_q    = is_div(op_q);

  always_comb begin
    op_in = op[2:0];
    a_neg = a_signed(op_in) & A[WIDTH-1];
    b_neg = b_signed(op_in) & B[WIDTH-1];
    mag_a = a_neg ? -A : A;
    mag_b = b_neg ? -B : B;
    // Remainder follows the dividend; a zero divisor leaves the all-ones quotient alone.
    if (!is_div(op_in))
      neg_in = a_neg ^ b_neg;
    else if (op_in[1])
      neg_in = a_neg;
    else
      neg_in = (a_neg ^ b_neg) & (B != '0);
  end

  always_comb begin
    prod = neg_q ? -acc : acc;
    quo  = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem  = neg_q ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    case (op_q)
      MULDIV_MUL:                              result = prod[WIDTH-1:0];
      MULDIV_MULH, MULDIV_MULHSU, MULDIV_MULHU: result = prod[2*WIDTH-1:WIDTH];
      MULDIV_DIV, MULDIV_DIVU:                 result = quo;
      default:                                 result = rem;
    endcase
  end

  mul_div_step #(.WIDTH(WIDTH)) u_step (
    .is_div   (div_q),
    .acc      (acc),
    .opnd     (opnd),
    .acc_next (acc_next)
  );

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state     <= IDLE;
      cnt       <= '0;
      op_q      <= MULDIV_MUL;
      opnd      <= '0;
      acc       <= '0;
      neg_q     <= 1'b0;
      out_valid <= 1'b0;
      Out       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            op_q  <= op_in;
            neg_q <= neg_in;
            cnt   <= '0;
            state <= BUSY;
            if (is_div(op_in)) begin
              acc  <= {{WIDTH{1'b0}}, mag_a};
              opnd <= mag_b;
            end else begin
              acc  <= {{WIDTH{1'b0}}, mag_b};
              opnd <= mag_a;
            end
          end
        end
        BUSY: begin
          acc <= acc_next;
          if (cnt == LAST) begin
            cnt   <= '0;
            state <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          // First DONE cycle applies the sign fix-up; the result then holds until taken.
          if (!out_valid) begin
            out_valid <= 1'b1;
            Out       <= result;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            Out       <= '0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
